// File: rtl/clk_delay_monitor.sv
// Measures the delay from a rising edge of the delay-stage input clock to the next rising edge of its output clock, in emu_dt LSBs.
// Latency: meas_valid rises one emu_clk cycle after the output edge and stays high until the consumer takes the result.
// Backpressure: while a result waits for meas_ready, new input edges are not measured and are counted in miss_cnt (saturating).
module clk_delay_monitor #(
  parameter int DT_WIDTH  = 27,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        emu_clk,
  input  logic                        emu_rst,
  input  logic signed [DT_WIDTH-1:0]  emu_dt,
  input  logic        [7:0]           code,
  input  logic                        clk_i_val,
  input  logic                        clk_o_val,
  output logic        [ACC_WIDTH-1:0] meas_delay,
  output logic        [7:0]           meas_code,
  output logic                        meas_ovf,
  output logic                        meas_valid,
  input  logic                        meas_ready,
  output logic        [7:0]           miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_clk_i_d;
  logic                   r_clk_o_d;
  logic                   w_i_rise;
  logic                   w_o_rise;

  logic [ACC_WIDTH-1:0]   w_dt_eff;
  logic [ACC_WIDTH:0]     w_sum;

  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   w_acc_nxt;
  logic                   r_ovf;
  logic                   w_ovf_nxt;
  logic [7:0]             r_code_cap;
  logic [7:0]             w_code_cap_nxt;

  logic [ACC_WIDTH-1:0]   r_meas_delay;
  logic [ACC_WIDTH-1:0]   w_meas_delay_nxt;
  logic [7:0]             r_meas_code;
  logic [7:0]             w_meas_code_nxt;
  logic                   r_meas_ovf;
  logic                   w_meas_ovf_nxt;
  logic                   r_meas_valid;
  logic [7:0]             r_miss_cnt;
  logic                   w_miss_inc;

  assign w_i_rise = clk_i_val & ~r_clk_i_d;
  assign w_o_rise = clk_o_val & ~r_clk_o_d;

  // Negative timesteps contribute nothing; positive ones are zero-extended to the accumulator width.
  always_comb begin
    w_dt_eff = '0;
    if (!emu_dt[DT_WIDTH-1]) begin
      w_dt_eff[DT_WIDTH-1:0] = emu_dt;
    end
  end

  // One extra bit catches the carry so the accumulator can saturate instead of wrapping.
  assign w_sum = {1'b0, r_acc} + {1'b0, w_dt_eff};

  // Edge history: previous sample of each clock, cleared by reset so a high level at release counts as an edge.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      r_clk_i_d <= 1'b0;
      r_clk_o_d <= 1'b0;
    end else begin
      r_clk_i_d <= clk_i_val;
      r_clk_o_d <= clk_o_val;
    end
  end

  // Next-state and datapath decisions; every target holds its value unless a transition says otherwise.
  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_ovf_nxt        = r_ovf;
    w_code_cap_nxt   = r_code_cap;
    w_meas_delay_nxt = r_meas_delay;
    w_meas_code_nxt  = r_meas_code;
    w_meas_ovf_nxt   = r_meas_ovf;
    w_miss_inc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_i_rise && w_o_rise) begin
          w_meas_delay_nxt = '0;
          w_meas_code_nxt  = code;
          w_meas_ovf_nxt   = 1'b0;
          w_state_nxt      = S_HOLD;
        end else if (w_i_rise) begin
          w_acc_nxt      = w_dt_eff;
          w_code_cap_nxt = code;
          w_ovf_nxt      = 1'b0;
          w_state_nxt    = S_MEASURE;
        end
      end
      S_MEASURE: begin
        // An input edge arriving during a measurement is never the start of one.
        w_miss_inc = w_i_rise;
        if (w_o_rise) begin
          // The output-edge cycle's own timestep is not part of the delay.
          w_meas_delay_nxt = r_acc;
          w_meas_code_nxt  = r_code_cap;
          w_meas_ovf_nxt   = r_ovf;
          w_state_nxt      = S_HOLD;
        end else if (w_sum[ACC_WIDTH]) begin
          w_acc_nxt = '1;
          w_ovf_nxt = 1'b1;
        end else begin
          w_acc_nxt = w_sum[ACC_WIDTH-1:0];
        end
      end
      S_HOLD: begin
        w_miss_inc = w_i_rise;
        if (meas_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, captured code and result registers; meas_valid tracks entry into and exit from HOLD.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_code_cap   <= 8'h00;
      r_meas_delay <= '0;
      r_meas_code  <= 8'h00;
      r_meas_ovf   <= 1'b0;
      r_meas_valid <= 1'b0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_ovf        <= w_ovf_nxt;
      r_code_cap   <= w_code_cap_nxt;
      r_meas_delay <= w_meas_delay_nxt;
      r_meas_code  <= w_meas_code_nxt;
      r_meas_ovf   <= w_meas_ovf_nxt;
      r_meas_valid <= (w_state_nxt == S_HOLD);
    end
  end

  // Missed-edge counter sticks at 255.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      r_miss_cnt <= 8'h00;
    end else if (w_miss_inc && (r_miss_cnt != 8'hFF)) begin
      r_miss_cnt <= r_miss_cnt + 8'h01;
    end
  end

  assign meas_delay = r_meas_delay;
  assign meas_code  = r_meas_code;
  assign meas_ovf   = r_meas_ovf;
  assign meas_valid = r_meas_valid;
  assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_clk_delay_monitor.sv
// Testbench for clk_delay_monitor: a wide instance (27/32) and a narrow instance (8/8) share one stimulus stream.
// Directed scenarios with hand-computed results, then randomized edges/timesteps/handshakes with occasional resets.
// Every cycle both instances are compared against an event-level model built from edge lists and timestep sums.
module tb_clk_delay_monitor;

  localparam int DTW_A  = 27;
  localparam int ACCW_A = 32;
  localparam int DTW_B  = 8;
  localparam int ACCW_B = 8;

  logic                     emu_clk = 1'b0;
  logic                     emu_rst = 1'b0;
  logic signed [DTW_A-1:0]  emu_dt_a;
  logic signed [DTW_B-1:0]  emu_dt_b;
  logic [7:0]               code;
  logic                     clk_i_val;
  logic                     clk_o_val;
  logic                     meas_ready;

  logic [ACCW_A-1:0]        a_delay;
  logic [7:0]               a_code;
  logic                     a_ovf;
  logic                     a_valid;
  logic [7:0]               a_miss;
  logic [ACCW_B-1:0]        b_delay;
  logic [7:0]               b_code;
  logic                     b_ovf;
  logic                     b_valid;
  logic [7:0]               b_miss;

  int n_chk  = 0;
  int n_fail = 0;
  int dt_v   = 0;

  // Reference model, one slot per instance.
  longint m_max[2];
  bit     m_pi[2];
  bit     m_po[2];
  bit     m_busy[2];
  bit     m_pend[2];
  longint m_sum[2];
  int     m_cap[2];
  longint m_delay[2];
  int     m_code[2];
  bit     m_ovf[2];
  int     m_miss[2];

  clk_delay_monitor #(.DT_WIDTH(DTW_A), .ACC_WIDTH(ACCW_A)) u_dut_a (
    .emu_clk    (emu_clk),
    .emu_rst    (emu_rst),
    .emu_dt     (emu_dt_a),
    .code       (code),
    .clk_i_val  (clk_i_val),
    .clk_o_val  (clk_o_val),
    .meas_delay (a_delay),
    .meas_code  (a_code),
    .meas_ovf   (a_ovf),
    .meas_valid (a_valid),
    .meas_ready (meas_ready),
    .miss_cnt   (a_miss)
  );

  clk_delay_monitor #(.DT_WIDTH(DTW_B), .ACC_WIDTH(ACCW_B)) u_dut_b (
    .emu_clk    (emu_clk),
    .emu_rst    (emu_rst),
    .emu_dt     (emu_dt_b),
    .code       (code),
    .clk_i_val  (clk_i_val),
    .clk_o_val  (clk_o_val),
    .meas_delay (b_delay),
    .meas_code  (b_code),
    .meas_ovf   (b_ovf),
    .meas_valid (b_valid),
    .meas_ready (meas_ready),
    .miss_cnt   (b_miss)
  );

  always #5 emu_clk = ~emu_clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_dt(input int v);
    dt_v     = v;
    emu_dt_a = DTW_A'(v);
    emu_dt_b = DTW_B'(v);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pi[k] = 0; m_po[k] = 0; m_busy[k] = 0; m_pend[k] = 0;
      m_sum[k] = 0; m_cap[k] = 0; m_delay[k] = 0; m_code[k] = 0;
      m_ovf[k] = 0; m_miss[k] = 0;
    end
  endtask

  // Event view: an input edge opens a window, timesteps inside it are summed, the output edge closes it.
  task automatic model_step();
    bit     ir, orr;
    longint dt;
    dt = (dt_v < 0) ? 0 : dt_v;
    for (int k = 0; k < 2; k++) begin
      ir = clk_i_val && !m_pi[k];
      orr = clk_o_val && !m_po[k];
      m_pi[k] = clk_i_val;
      m_po[k] = clk_o_val;
      if (m_pend[k]) begin
        if (ir && m_miss[k] < 255) m_miss[k]++;
        if (meas_ready) m_pend[k] = 0;
      end else if (m_busy[k]) begin
        if (ir && m_miss[k] < 255) m_miss[k]++;
        if (orr) begin
          m_delay[k] = (m_sum[k] > m_max[k]) ? m_max[k] : m_sum[k];
          m_ovf[k]   = (m_sum[k] > m_max[k]);
          m_code[k]  = m_cap[k];
          m_pend[k]  = 1;
          m_busy[k]  = 0;
        end else begin
          m_sum[k] += dt;
        end
      end else if (ir) begin
        if (orr) begin
          m_delay[k] = 0; m_ovf[k] = 0; m_code[k] = code; m_pend[k] = 1;
        end else begin
          m_busy[k] = 1; m_sum[k] = dt; m_cap[k] = code;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("a_valid", a_valid, m_pend[0]);
    chk("a_delay", a_delay, m_delay[0]);
    chk("a_code",  a_code,  m_code[0]);
    chk("a_ovf",   a_ovf,   m_ovf[0]);
    chk("a_miss",  a_miss,  m_miss[0]);
    chk("b_valid", b_valid, m_pend[1]);
    chk("b_delay", b_delay, m_delay[1]);
    chk("b_code",  b_code,  m_code[1]);
    chk("b_ovf",   b_ovf,   m_ovf[1]);
    chk("b_miss",  b_miss,  m_miss[1]);
  endtask

  // Inputs are stable from the previous falling edge; outputs are sampled on the next falling edge.
  task automatic step();
    @(posedge emu_clk);
    model_step();
    @(negedge emu_clk);
    check_all();
  endtask

  // Reset is raised between clock edges; outputs must clear before any clock edge arrives.
  task automatic do_reset();
    emu_rst = 1'b1;
    #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_delay", a_delay, 0);
    chk("rst_a_code",  a_code,  0);
    chk("rst_a_ovf",   a_ovf,   0);
    chk("rst_a_miss",  a_miss,  0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_delay", b_delay, 0);
    chk("rst_b_miss",  b_miss,  0);
    model_reset();
    @(posedge emu_clk);
    @(negedge emu_clk);
    emu_rst = 1'b0;
  endtask

  task automatic clocks_low();
    clk_i_val = 1'b0;
    clk_o_val = 1'b0;
  endtask

  initial begin
    m_max[0] = (64'd1 << ACCW_A) - 1;
    m_max[1] = (64'd1 << ACCW_B) - 1;
    clocks_low();
    set_dt(100);
    code       = 8'h00;
    meas_ready = 1'b1;
    #2;
    do_reset();

    // Constant timestep 100, input edge cycle 10, output edge cycle 15.
    code = 8'hA5;
    repeat (10) step();
    clk_i_val = 1'b1;
    step();
    code = 8'h11;
    repeat (4) step();
    clk_o_val = 1'b1;
    step();
    chk("d1_valid_c16", a_valid, 1);
    chk("d1_delay",     a_delay, 500);
    chk("d1_code",      a_code,  8'hA5);
    chk("d1_ovf",       a_ovf,   0);
    chk("d1_b_delay",   b_delay, 255);
    chk("d1_b_ovf",     b_ovf,   1);
    step();
    chk("d1_valid_c17", a_valid, 0);
    clocks_low();
    repeat (3) step();

    // Both edges in the same cycle give a zero delay.
    do_reset();
    repeat (5) step();
    code = 8'h3C;
    clk_i_val = 1'b1;
    clk_o_val = 1'b1;
    step();
    chk("d2_valid", a_valid, 1);
    chk("d2_delay", a_delay, 0);
    chk("d2_code",  a_code,  8'h3C);
    clocks_low();
    repeat (2) step();

    // Narrow accumulator saturates with an output edge 4 cycles after the input edge.
    do_reset();
    set_dt(100);
    repeat (2) step();
    clk_i_val = 1'b1;
    step();
    repeat (3) step();
    clk_o_val = 1'b1;
    step();
    chk("d3_b_delay", b_delay, 255);
    chk("d3_b_ovf",   b_ovf,   1);
    chk("d3_a_delay", a_delay, 400);
    clocks_low();
    repeat (2) step();

    // Negative timesteps count as zero.
    do_reset();
    set_dt(10);
    repeat (10) step();
    clk_i_val = 1'b1;
    step();
    set_dt(-5);
    repeat (2) step();
    set_dt(10);
    step();
    clk_o_val = 1'b1;
    step();
    chk("d4_delay",   a_delay, 20);
    chk("d4_b_delay", b_delay, 20);
    clocks_low();
    repeat (2) step();

    // Result held while the consumer stalls; input edges during the stall are missed.
    do_reset();
    set_dt(7);
    meas_ready = 1'b0;
    clk_i_val = 1'b1;
    step();
    step();
    clk_o_val = 1'b1;
    step();
    clocks_low();
    for (int c = 0; c < 50; c++) begin
      clk_i_val = (c == 10 || c == 20 || c == 30);
      step();
    end
    chk("d5_valid", a_valid, 1);
    chk("d5_delay", a_delay, 14);
    chk("d5_miss",  a_miss,  3);
    for (int c = 0; c < 600; c++) begin
      clk_i_val = ~clk_i_val;
      step();
    end
    chk("d5_miss_sat",   a_miss, 255);
    chk("d5_b_miss_sat", b_miss, 255);
    chk("d5_delay_kept", a_delay, 14);
    clocks_low();
    meas_ready = 1'b1;
    repeat (2) step();

    // Reset in the middle of a measurement, then a clean pair.
    do_reset();
    set_dt(10);
    clk_i_val = 1'b1;
    step();
    repeat (3) step();
    clocks_low();
    do_reset();
    repeat (3) step();
    clk_i_val = 1'b1;
    step();
    repeat (2) step();
    clk_o_val = 1'b1;
    step();
    chk("d6_valid", a_valid, 1);
    chk("d6_delay", a_delay, 30);
    clocks_low();
    repeat (2) step();

    // Randomized traffic; clocks may be high across a reset release.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) clk_i_val = ~clk_i_val;
        if ($urandom_range(0, 4) == 0) clk_o_val = ~clk_o_val;
        meas_ready = ($urandom_range(0, 2) != 0);
        code = 8'($urandom_range(0, 255));
        set_dt(($urandom_range(0, 9) == 0) ? -int'($urandom_range(1, 20))
                                           : int'($urandom_range(0, 120)));
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_delay_monitor.md
CLK_DELAY_MONITOR -- requirements
Module: clk_delay_monitor

Interface
REQ-001 SHALL have parameter DT_WIDTH, default 27, width of the signed emulator timestep word.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, width of the unsigned measured-delay accumulator (ACC_WIDTH >= DT_WIDTH).
REQ-003 SHALL have port emu_clk  input  1  the single emulator clock; all state updates on its rising edge.
REQ-004 SHALL have port emu_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port emu_dt  input  DT_WIDTH (signed)  timestep advanced from the current emu_clk cycle to the next.
REQ-006 SHALL have port code  input  8  delay code currently applied to the clock delay stage.
REQ-007 SHALL have port clk_i_val  input  1  delay-stage input clock value, one sample per emu_clk cycle.
REQ-008 SHALL have port clk_o_val  input  1  delay-stage output clock value, one sample per emu_clk cycle.
REQ-009 SHALL have port meas_delay  output  ACC_WIDTH  measured input-to-output rising-edge delay, in emu_dt LSBs.
REQ-010 SHALL have port meas_code  output  8  code captured at the input edge of the measurement.
REQ-011 SHALL have port meas_ovf  output  1  set when meas_delay saturated.
REQ-012 SHALL have port meas_valid  output  1  result available.
REQ-013 SHALL have port meas_ready  input  1  consumer accepts result.
REQ-014 SHALL have port miss_cnt  output  8  saturating count of input rising edges not measured.

Function
REQ-015 SHALL detect rising edges by comparing each sample of clk_i_val and clk_o_val with its registered value from the previous cycle (i_rise, o_rise).
REQ-016 SHALL treat negative emu_dt as zero when accumulating (dt_eff = max(emu_dt, 0), zero-extended to ACC_WIDTH).
REQ-017 SHALL implement states IDLE, MEASURE, HOLD.
REQ-018 IDLE, i_rise and not o_rise: acc <= dt_eff, capture code, ovf <= 0, go MEASURE.
REQ-019 IDLE, i_rise and o_rise same cycle: load meas_delay = 0, meas_code = code, meas_ovf = 0, go HOLD.
REQ-020 IDLE, o_rise without i_rise: ignored, no state change.
REQ-021 MEASURE, no o_rise: acc <= acc + dt_eff, saturating at 2^ACC_WIDTH-1; saturation sets ovf, which stays set until the next measurement start.
REQ-022 MEASURE, o_rise: meas_delay <= acc (without adding the current dt_eff), meas_code <= captured code, meas_ovf <= ovf, go HOLD; result equals sum of emu_dt from input-edge cycle up to, not including, output-edge cycle.
REQ-023 MEASURE, i_rise without o_rise: measurement continues unchanged, miss_cnt increments.
REQ-024 HOLD: meas_valid = 1; meas_delay, meas_code and meas_ovf stable until handshake.
REQ-025 HOLD, meas_valid and meas_ready high at a rising edge: handshake; go IDLE, meas_valid = 0 next cycle.
REQ-026 HOLD, any i_rise, including the handshake cycle: not measured, miss_cnt increments.
REQ-027 miss_cnt SHALL saturate at 255 and never wrap.
REQ-028 meas_valid SHALL be registered, asserted exactly from the cycle after entering HOLD; min result latency from o_rise is one cycle.
REQ-029 meas_ready SHALL be ignored outside HOLD.

Reset
REQ-030 emu_rst high SHALL immediately force IDLE, meas_valid = 0, meas_delay = 0, meas_code = 0, meas_ovf = 0, miss_cnt = 0, acc = 0, and both edge-history registers = 0.
REQ-031 Reset mid-MEASURE or mid-HOLD SHALL discard the pending result with no partial output.
REQ-032 A clock input already high at reset release SHALL register as an edge on the first cycle.

Verification
REQ-033 emu_dt = 100 constant; clk_i_val rises cycle 10, clk_o_val rises cycle 15, meas_ready = 1 -> meas_valid high cycle 16 only, meas_delay = 500, meas_ovf = 0.
REQ-034 Both clocks rise cycle 5, code = 8'h3C -> meas_valid cycle 6, meas_delay = 0, meas_code = 8'h3C.
REQ-035 ACC_WIDTH = 8, emu_dt = 100, output edge 4 cycles after input -> meas_delay = 255, meas_ovf = 1.
REQ-036 meas_ready = 0 held 50 cycles, 3 input edges during HOLD -> result unchanged throughout, miss_cnt = 3; 300 such edges -> miss_cnt = 255.
REQ-037 emu_dt = -5 on cycles 11-12, otherwise 10; edges at 10 and 14 -> meas_delay = 20.
REQ-038 emu_rst pulsed in MEASURE -> all outputs 0 immediately; following clean edge pair measures correctly.
